// File: rtl/hls_seq_pkg.sv
// hls_seq_pkg: shared types for the HLS transaction sequencer.
// Holds the sequencer FSM state encoding, the default counter width and
// the latency/timestamp type used by the bench and by default-width builds.
package hls_seq_pkg;

   localparam int DEF_CNT_W = 32;

   typedef logic [DEF_CNT_W-1:0] lat_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_GAP   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/ts_fifo.sv
// ts_fifo: synchronous DEPTH x W timestamp FIFO holding accept times of outstanding transactions.
// Latency: a push is visible at dout_o/level_o the cycle after it is taken; dout_o is the current head.
// Backpressure: push on full without a pop and pop on empty are dropped; push+pop together is legal when non-empty.
// Ports: clock/reset_n (sync, active-low), push_i/din_i, pop_i/dout_o, full_o, empty_o, level_o.
module ts_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   level_o
);

   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   level_q;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop_i && (level_q != '0);
   // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
   assign do_push = push_i && ((level_q != FULL_LVL) || do_pop);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset: it is only read while level_q is non-zero.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

endmodule

// File: rtl/hls_txn_sequencer.sv
// hls_txn_sequencer: drives an HLS block over ap_start/ap_ready/ap_done, issuing cfg_txn_count starts with cfg_gap idle cycles.
// Latency: ap_start rises one cycle after go; counters/statistics update the cycle after accept/ap_done; finish one cycle after DONE.
// Backpressure: ap_start holds until ap_ready; it drops while DEPTH transactions are outstanding and resumes after a done.
// Ports: clock/reset_n, go/abort/cfg_* from the test program, ap_* to/from the DUT, busy/finish/txn_*/lat_*/err_overrun status.
module hls_txn_sequencer
   import hls_seq_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             go,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_txn_count,
   input  logic [7:0]       cfg_gap,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             busy,
   output logic             finish,
   output logic [CNT_W-1:0] txn_issued,
   output logic [CNT_W-1:0] txn_done,
   output logic [CNT_W-1:0] lat_last,
   output logic [CNT_W-1:0] lat_min,
   output logic [CNT_W-1:0] lat_max,
   output logic             err_overrun
);

   localparam int              LW         = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0]   ALMOST_LVL = LW'(DEPTH - 1);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] tick_q;
   logic [CNT_W-1:0] cfg_count_q, cfg_count_d;
   logic [7:0]       cfg_gap_q, cfg_gap_d;
   logic [7:0]       gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0] txn_issued_q, txn_issued_d;
   logic [CNT_W-1:0] txn_done_q, txn_done_d;
   logic [CNT_W-1:0] lat_last_q, lat_last_d;
   logic [CNT_W-1:0] lat_min_q, lat_min_d;
   logic [CNT_W-1:0] lat_max_q, lat_max_d;
   logic             ap_start_q, ap_start_d;
   logic             busy_q, busy_d;
   logic             finish_q, finish_d;
   logic             err_q, err_d;

   logic             fifo_full, fifo_empty, full_next;
   logic [LW-1:0]    fifo_level;
   logic [CNT_W-1:0] fifo_head, lat;
   logic             accept, bypass, push, pop, done_evt, overrun;

   assign accept   = ap_start_q && ap_ready;
   // Done together with an accept while nothing is queued is the same transaction finishing at once.
   assign bypass   = accept && ap_done && fifo_empty;
   assign push     = accept && !bypass;
   assign pop      = ap_done && !fifo_empty;
   assign done_evt = pop || bypass;
   assign overrun  = ap_done && fifo_empty && !accept;
   assign lat      = bypass ? '0 : (tick_q - fifo_head);

   // ap_start is registered, so it must be gated on the occupancy after this edge.
   assign full_next = pop ? (fifo_full && push)
                          : (fifo_full || (push && (fifo_level == ALMOST_LVL)));

   ts_fifo #(.DEPTH(DEPTH), .W(CNT_W)) u_ts_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (push),
      .din_i   (tick_q),
      .pop_i   (pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   always_comb begin
      state_d      = state_q;
      cfg_count_d  = cfg_count_q;
      cfg_gap_d    = cfg_gap_q;
      gap_cnt_d    = gap_cnt_q;
      txn_issued_d = txn_issued_q + CNT_W'(accept);
      txn_done_d   = txn_done_q + CNT_W'(done_evt);
      lat_last_d   = lat_last_q;
      lat_min_d    = lat_min_q;
      lat_max_d    = lat_max_q;
      err_d        = err_q || overrun;
      if (done_evt) begin
         lat_last_d = lat;
         if (lat < lat_min_q) lat_min_d = lat;
         if (lat > lat_max_q) lat_max_d = lat;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (go) begin
               cfg_count_d  = cfg_txn_count;
               cfg_gap_d    = cfg_gap;
               txn_issued_d = '0;
               txn_done_d   = '0;
               lat_last_d   = '0;
               lat_min_d    = '1;
               lat_max_d    = '0;
               err_d        = 1'b0;
               state_d      = (cfg_txn_count == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (abort) begin
               state_d = S_DRAIN;
            end else if (accept) begin
               if (txn_issued_q + CNT_W'(1) == cfg_count_q) begin
                  state_d = S_DRAIN;
               end else if (cfg_gap_q != 8'd0) begin
                  state_d   = S_GAP;
                  gap_cnt_d = cfg_gap_q;
               end
            end
         end
         S_GAP: begin
            // gap_cnt_q holds the idle cycles still to spend, including this one.
            if (abort) begin
               state_d = S_DRAIN;
            end else if (gap_cnt_q == 8'd1) begin
               state_d = S_ISSUE;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         S_DRAIN: begin
            if (fifo_empty && !ap_done) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      ap_start_d = (state_d == S_ISSUE) && !full_next;
      busy_d     = state_d inside {S_ISSUE, S_GAP, S_DRAIN};
      // finish trails DONE by a cycle and drops as soon as a new run is launched.
      finish_d   = (state_q == S_DONE) && !go;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         tick_q       <= '0;
         cfg_count_q  <= '0;
         cfg_gap_q    <= '0;
         gap_cnt_q    <= '0;
         txn_issued_q <= '0;
         txn_done_q   <= '0;
         lat_last_q   <= '0;
         lat_min_q    <= '1;
         lat_max_q    <= '0;
         ap_start_q   <= 1'b0;
         busy_q       <= 1'b0;
         finish_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_q + 1'b1;
         cfg_count_q  <= cfg_count_d;
         cfg_gap_q    <= cfg_gap_d;
         gap_cnt_q    <= gap_cnt_d;
         txn_issued_q <= txn_issued_d;
         txn_done_q   <= txn_done_d;
         lat_last_q   <= lat_last_d;
         lat_min_q    <= lat_min_d;
         lat_max_q    <= lat_max_d;
         ap_start_q   <= ap_start_d;
         busy_q       <= busy_d;
         finish_q     <= finish_d;
         err_q        <= err_d;
      end
   end

   assign ap_start    = ap_start_q;
   assign busy        = busy_q;
   assign finish      = finish_q;
   assign txn_issued  = txn_issued_q;
   assign txn_done    = txn_done_q;
   assign lat_last    = lat_last_q;
   assign lat_min     = lat_min_q;
   assign lat_max     = lat_max_q;
   assign err_overrun = err_q;

endmodule

// File: tb/tb_hls_txn_sequencer.sv
// tb_hls_txn_sequencer: directed checks of hls_txn_sequencer at default width plus an 8-bit
// instance (sharing all inputs) for timestamp wrap. Each loop index k is one clock cycle;
// outputs are sampled 1 time unit after the rising edge, inputs driven right after.
module tb_hls_txn_sequencer;
   import hls_seq_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n, go, abort, ap_ready, ap_done;
   logic [31:0] cfg_txn_count;
   logic [7:0]  cfg_gap;
   logic        ap_start, busy, finish, err_overrun;
   lat_t        txn_issued, txn_done, lat_last, lat_min, lat_max;
   logic        ap_start8, busy8, finish8, err8;
   logic [7:0]  issued8, done8, last8, min8, max8;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   hls_txn_sequencer #(.CNT_W(32), .DEPTH(8)) dut (
      .clock(clock), .reset_n(reset_n), .go(go), .abort(abort),
      .cfg_txn_count(cfg_txn_count), .cfg_gap(cfg_gap),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
      .busy(busy), .finish(finish), .txn_issued(txn_issued), .txn_done(txn_done),
      .lat_last(lat_last), .lat_min(lat_min), .lat_max(lat_max), .err_overrun(err_overrun)
   );

   hls_txn_sequencer #(.CNT_W(8), .DEPTH(8)) dut8 (
      .clock(clock), .reset_n(reset_n), .go(go), .abort(abort),
      .cfg_txn_count(cfg_txn_count[7:0]), .cfg_gap(cfg_gap),
      .ap_start(ap_start8), .ap_ready(ap_ready), .ap_done(ap_done),
      .busy(busy8), .finish(finish8), .txn_issued(issued8), .txn_done(done8),
      .lat_last(last8), .lat_min(min8), .lat_max(max8), .err_overrun(err8)
   );

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; go = 1'b0; abort = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
      cfg_txn_count = 32'd0; cfg_gap = 8'd0;
      cyc();
      cyc();
      // Reset state
      chk_b("rst_ap_start", ap_start, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_finish", finish, 1'b0);
      chk_w("rst_issued", txn_issued, 32'd0);
      chk_w("rst_done", txn_done, 32'd0);
      chk_w("rst_lat_last", lat_last, 32'd0);
      chk_w("rst_lat_max", lat_max, 32'd0);
      chk_w("rst_lat_min", lat_min, 32'hFFFF_FFFF);
      chk_b("rst_err", err_overrun, 1'b0);
      chk_w("rst_lat_min8", {24'd0, min8}, 32'h0000_00FF);
      reset_n = 1'b1;
      cyc();

      // 1: count 3, gap 0, ready always, done 5 cycles after each accept (cycles 1..3 -> 6..8)
      for (int k = 0; k < 12; k++) begin
         chk_b("t1_ap_start", ap_start, (k >= 1 && k <= 3));
         if (k == 1)  chk_b("t1_busy", busy, 1'b1);
         if (k == 10) chk_b("t1_finish_lo", finish, 1'b0);
         if (k == 11) chk_b("t1_finish", finish, 1'b1);
         go = (k == 0); abort = 1'b0; cfg_txn_count = 32'd3; cfg_gap = 8'd0;
         ap_ready = 1'b1;
         ap_done  = (k >= 6 && k <= 8);
         cyc();
      end
      chk_w("t1_lat_last", lat_last, 32'd5);
      chk_w("t1_lat_min", lat_min, 32'd5);
      chk_w("t1_lat_max", lat_max, 32'd5);
      chk_w("t1_txn_done", txn_done, 32'd3);
      chk_w("t1_txn_issued", txn_issued, 32'd3);
      chk_b("t1_busy_end", busy, 1'b0);

      // 2: count 4, gap 2, ready 3 cycles after each start rises; done 1 cycle after accept
      for (int k = 0; k < 27; k++) begin
         chk_b("t2_ap_start", ap_start, (k >= 1 && k <= 22 && ((k - 1) % 6) <= 3));
         if (k == 1)  chk_b("t2_finish_drop", finish, 1'b0);
         if (k == 25) chk_b("t2_finish_lo", finish, 1'b0);
         if (k == 26) chk_b("t2_finish", finish, 1'b1);
         go = (k == 0); abort = 1'b0; cfg_txn_count = 32'd4; cfg_gap = 8'd2;
         ap_ready = (k >= 1 && k <= 22 && ((k - 1) % 6) == 3);
         ap_done  = (k >= 5 && k <= 23 && ((k - 5) % 6) == 0);
         cyc();
      end
      chk_w("t2_txn_issued", txn_issued, 32'd4);
      chk_w("t2_txn_done", txn_done, 32'd4);
      chk_w("t2_lat_min", lat_min, 32'd1);
      chk_w("t2_lat_max", lat_max, 32'd1);

      // 3: count 12, DUT withholds done until the FIFO fills; dones cycles 11..22
      for (int k = 0; k < 26; k++) begin
         chk_b("t3_ap_start", ap_start, ((k >= 1 && k <= 8) || (k >= 12 && k <= 15)));
         if (k == 10) chk_w("t3_issued_full", txn_issued, 32'd8);
         if (k == 24) chk_b("t3_finish_lo", finish, 1'b0);
         if (k == 25) chk_b("t3_finish", finish, 1'b1);
         go = (k == 0); abort = 1'b0; cfg_txn_count = 32'd12; cfg_gap = 8'd0;
         ap_ready = 1'b1;
         ap_done  = (k >= 11 && k <= 22);
         cyc();
      end
      chk_w("t3_txn_issued", txn_issued, 32'd12);
      chk_w("t3_txn_done", txn_done, 32'd12);
      chk_w("t3_lat_min", lat_min, 32'd7);
      chk_w("t3_lat_max", lat_max, 32'd10);
      chk_w("t3_lat_last", lat_last, 32'd7);

      // 4: combinational DUT, ready = done = ap_start (cycles 1..3)
      for (int k = 0; k < 7; k++) begin
         chk_b("t4_ap_start", ap_start, (k >= 1 && k <= 3));
         if (k == 6) chk_b("t4_finish", finish, 1'b1);
         go = (k == 0); abort = 1'b0; cfg_txn_count = 32'd3; cfg_gap = 8'd0;
         ap_ready = (k >= 1 && k <= 3);
         ap_done  = (k >= 1 && k <= 3);
         cyc();
      end
      chk_w("t4_lat_last", lat_last, 32'd0);
      chk_w("t4_lat_min", lat_min, 32'd0);
      chk_w("t4_lat_max", lat_max, 32'd0);
      chk_w("t4_txn_done", txn_done, 32'd3);
      chk_b("t4_err", err_overrun, 1'b0);

      // 5a: reset mid-run with two transactions queued, then spurious done in IDLE
      for (int k = 0; k < 7; k++) begin
         if (k == 3) chk_w("t5_issued_pre", txn_issued, 32'd2);
         if (k == 3) chk_b("t5_start_pre", ap_start, 1'b1);
         if (k == 4) chk_b("t5_rst_start", ap_start, 1'b0);
         if (k == 4) chk_b("t5_rst_busy", busy, 1'b0);
         if (k == 4) chk_w("t5_rst_issued", txn_issued, 32'd0);
         if (k == 4) chk_w("t5_rst_lat_min", lat_min, 32'hFFFF_FFFF);
         if (k == 6) chk_b("t5_overrun", err_overrun, 1'b1);
         if (k == 6) chk_w("t5_ovr_done", txn_done, 32'd0);
         if (k == 6) chk_w("t5_ovr_lat_last", lat_last, 32'd0);
         reset_n = (k != 3);
         go = (k == 0); abort = 1'b0; cfg_txn_count = 32'd10; cfg_gap = 8'd0;
         ap_ready = (k >= 1 && k <= 2);
         ap_done  = (k == 5);
         cyc();
      end

      // 5b: count 10, abort in the cycle of the 4th accept; dones cycles 3..6
      for (int k = 0; k < 10; k++) begin
         chk_b("t5b_ap_start", ap_start, (k >= 1 && k <= 4));
         if (k == 1) chk_b("t5b_err_clr", err_overrun, 1'b0);
         if (k == 5) chk_b("t5b_busy_drain", busy, 1'b1);
         if (k == 8) chk_b("t5b_finish_lo", finish, 1'b0);
         if (k == 9) chk_b("t5b_finish", finish, 1'b1);
         go = (k == 0); abort = (k == 4); cfg_txn_count = 32'd10; cfg_gap = 8'd0;
         ap_ready = (k >= 1 && k <= 4);
         ap_done  = (k >= 3 && k <= 6);
         cyc();
      end
      chk_w("t5b_txn_issued", txn_issued, 32'd4);
      chk_w("t5b_txn_done", txn_done, 32'd4);
      chk_w("t5b_lat_last", lat_last, 32'd2);
      chk_b("t5b_err", err_overrun, 1'b0);

      // 6: tick wrap; after reset cycle 1+j has tick j, so accept at tick 0xFE, done at 0x03
      for (int k = 0; k < 264; k++) begin
         if (k == 2) chk_w("t6_lat_min8_rst", {24'd0, min8}, 32'h0000_00FF);
         if (k >= 250 && k <= 258) chk_b("t6_ap_start8", ap_start8, (k == 255));
         if (k == 261) chk_w("t6_lat_last8", {24'd0, last8}, 32'd5);
         if (k == 261) chk_w("t6_lat_last", lat_last, 32'd5);
         if (k == 262) chk_b("t6_finish8_lo", finish8, 1'b0);
         if (k == 263) chk_b("t6_finish8", finish8, 1'b1);
         reset_n = (k != 0);
         go = (k == 254); abort = 1'b0; cfg_txn_count = 32'd1; cfg_gap = 8'd0;
         ap_ready = (k == 255);
         ap_done  = (k == 260);
         cyc();
      end
      chk_w("t6_issued8", {24'd0, issued8}, 32'd1);
      chk_w("t6_done8", {24'd0, done8}, 32'd1);
      chk_w("t6_lat_min8", {24'd0, min8}, 32'd5);
      chk_w("t6_lat_max8", {24'd0, max8}, 32'd5);
      chk_b("t6_err8", err8, 1'b0);
      chk_b("t6_busy8", busy8, 1'b0);
      chk_w("t6_lat_max", lat_max, 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
